// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Recovers pixel coordinates and colour from a VGA-style sync/blank/colour
//   stream. The decoder measures line and frame timing against the configured
//   geometry. It only presents pixels as valid once it has locked to that
//   geometry.
//
// Ports
//   iCLK, reset_n            pixel clock (rising edge), async active-low reset
//   iVGA_HS, iVGA_VS         horizontal / vertical sync, active low
//   iVGA_BLANK               high during active video
//   iRed, iGreen, iBlue      1-bit pixel colour
//   oCurrent_X, oCurrent_Y   active column / row of the output pixel
//   oPix_Valid               output pixel is active video and decoder is locked
//   oR, oG, oB               recovered colour, zero when not valid
//   oLocked                  timing matches the configured geometry
//   oFrame_Start             one-clock pulse per VS falling edge
//   oTiming_Err              one-clock pulse when lock is lost
//
// Lock FSM
//   state  | meaning
//   SEARCH | waiting for a VS falling edge after at least one HS edge
//   VERIFY | counting consecutive good frames toward LOCK_FRAMES
//   LOCKED | timing confirmed, pixels presented as valid

module vga_sync_decoder #(
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       iCLK,
  input  logic       reset_n,
  input  logic       iVGA_HS,
  input  logic       iVGA_VS,
  input  logic       iVGA_BLANK,
  input  logic       iRed,
  input  logic       iGreen,
  input  logic       iBlue,
  output logic [9:0] oCurrent_X,
  output logic [9:0] oCurrent_Y,
  output logic       oPix_Valid,
  output logic       oR,
  output logic       oG,
  output logic       oB,
  output logic       oLocked,
  output logic       oFrame_Start,
  output logic       oTiming_Err
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [9:0]  CNT_MAX   = 10'h3FF;
  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [9:0]  H_ACT_W   = 10'(H_ACT);
  localparam logic [9:0]  V_ACT_W   = 10'(V_ACT);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [7:0]  LOCK_W    = 8'(LOCK_FRAMES);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  // stage 1: input registers plus delayed sync copies for edge detection
  logic       hs_s1_q, vs_s1_q, hs_dly_q, vs_dly_q;
  logic       blank_s1_q;
  logic [2:0] rgb_s1_q;

  // line / frame measurement
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] x_cnt_q, x_cnt_d;
  logic [9:0] y_cnt_q, y_cnt_d;
  logic [9:0] line_cnt_q, line_cnt_d;
  logic [9:0] act_lines_q, act_lines_d;
  logic       lines_ok_q, lines_ok_d;
  logic       hs_seen_q, hs_seen_d;

  // lock FSM
  logic [1:0] state_q, state_d;
  logic [7:0] good_cnt_q, good_cnt_d;
  logic       locked_q, locked_d;
  logic       timing_err_q, timing_err_d;
  logic       frame_start_q, frame_start_d;

  // stage 2: pixel outputs
  logic [9:0] x_out_q, x_out_d;
  logic [9:0] y_out_q, y_out_d;
  logic       valid_q, valid_d;
  logic [2:0] rgb_out_q, rgb_out_d;

  logic        hs_fall, vs_fall;
  logic [10:0] line_len;
  logic        line_active, line_good;
  logic [9:0]  lines_eff, act_eff;
  logic        ok_eff, frame_good, watchdog;
  logic [7:0]  good_inc;

  assign hs_fall = hs_dly_q & ~hs_s1_q;
  assign vs_fall = vs_dly_q & ~vs_s1_q;

  // Line/frame accounting. A line that ends in the same cycle as a VS edge
  // is folded into the frame result before the frame is judged.
  always_comb begin
    line_len    = {1'b0, h_cnt_q} + 11'd1;
    line_active = (x_cnt_q != 10'd0);
    line_good   = (line_len == H_TOTAL_W) &&
                  ((x_cnt_q == 10'd0) || (x_cnt_q == H_ACT_W));

    h_cnt_d = hs_fall ? 10'd0 : sat_inc(h_cnt_q);

    // the sample that carries the HS edge already belongs to the new line
    if (hs_fall)
      x_cnt_d = {9'd0, blank_s1_q};
    else if (blank_s1_q)
      x_cnt_d = sat_inc(x_cnt_q);
    else
      x_cnt_d = x_cnt_q;

    y_cnt_d = y_cnt_q;
    if (hs_fall && line_active)
      y_cnt_d = sat_inc(y_cnt_q);
    if (vs_fall)
      y_cnt_d = 10'd0;

    lines_eff  = hs_fall ? sat_inc(line_cnt_q) : line_cnt_q;
    act_eff    = (hs_fall && line_active) ? sat_inc(act_lines_q) : act_lines_q;
    ok_eff     = lines_ok_q & (~hs_fall | line_good);
    frame_good = (lines_eff == V_TOTAL_W) && (act_eff == V_ACT_W) && ok_eff;

    line_cnt_d  = vs_fall ? 10'd0 : lines_eff;
    act_lines_d = vs_fall ? 10'd0 : act_eff;
    lines_ok_d  = vs_fall ? 1'b1  : ok_eff;
    hs_seen_d   = hs_seen_q | hs_fall;
  end

  // Lock FSM. A saturated h_cnt means HS has vanished; that overrides any
  // frame result arriving in the same cycle.
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    timing_err_d = 1'b0;
    watchdog     = (h_cnt_q == CNT_MAX);
    good_inc     = good_cnt_q + 8'd1;

    case (state_q)
      ST_SEARCH: begin
        if (vs_fall && hs_seen_d) begin
          state_d    = ST_VERIFY;
          good_cnt_d = 8'd0;
        end
      end
      ST_VERIFY: begin
        if (watchdog) begin
          state_d    = ST_SEARCH;
          good_cnt_d = 8'd0;
        end else if (vs_fall) begin
          if (frame_good) begin
            good_cnt_d = good_inc;
            if (good_inc == LOCK_W)
              state_d = ST_LOCKED;
          end else begin
            good_cnt_d = 8'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (watchdog || (vs_fall && !frame_good)) begin
          state_d      = ST_SEARCH;
          good_cnt_d   = 8'd0;
          timing_err_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_SEARCH;
        good_cnt_d = 8'd0;
      end
    endcase

    locked_d      = (state_d == ST_LOCKED);
    frame_start_d = vs_fall;
  end

  // stage 2 pixel outputs, judged against the lock state seen by this pixel
  always_comb begin
    valid_d   = blank_s1_q & (state_q == ST_LOCKED);
    x_out_d   = hs_fall ? 10'd0 : x_cnt_q;
    y_out_d   = y_cnt_q;
    rgb_out_d = valid_d ? rgb_s1_q : 3'b000;
  end

  always_ff @(posedge iCLK or negedge reset_n) begin
    if (!reset_n) begin
      // syncs idle high, so no edge can be seen on the first sampled cycle
      hs_s1_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
      hs_dly_q      <= 1'b1;
      vs_dly_q      <= 1'b1;
      blank_s1_q    <= 1'b0;
      rgb_s1_q      <= 3'b000;
      h_cnt_q       <= 10'd0;
      x_cnt_q       <= 10'd0;
      y_cnt_q       <= 10'd0;
      line_cnt_q    <= 10'd0;
      act_lines_q   <= 10'd0;
      lines_ok_q    <= 1'b0;
      hs_seen_q     <= 1'b0;
      state_q       <= ST_SEARCH;
      good_cnt_q    <= 8'd0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
      frame_start_q <= 1'b0;
      x_out_q       <= 10'd0;
      y_out_q       <= 10'd0;
      valid_q       <= 1'b0;
      rgb_out_q     <= 3'b000;
    end else begin
      hs_s1_q       <= iVGA_HS;
      vs_s1_q       <= iVGA_VS;
      hs_dly_q      <= hs_s1_q;
      vs_dly_q      <= vs_s1_q;
      blank_s1_q    <= iVGA_BLANK;
      rgb_s1_q      <= {iRed, iGreen, iBlue};
      h_cnt_q       <= h_cnt_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      line_cnt_q    <= line_cnt_d;
      act_lines_q   <= act_lines_d;
      lines_ok_q    <= lines_ok_d;
      hs_seen_q     <= hs_seen_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      locked_q      <= locked_d;
      timing_err_q  <= timing_err_d;
      frame_start_q <= frame_start_d;
      x_out_q       <= x_out_d;
      y_out_q       <= y_out_d;
      valid_q       <= valid_d;
      rgb_out_q     <= rgb_out_d;
    end
  end

  assign oCurrent_X   = x_out_q;
  assign oCurrent_Y   = y_out_q;
  assign oPix_Valid   = valid_q;
  assign oR           = rgb_out_q[2];
  assign oG           = rgb_out_q[1];
  assign oB           = rgb_out_q[0];
  assign oLocked      = locked_q;
  assign oFrame_Start = frame_start_q;
  assign oTiming_Err  = timing_err_q;

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- iCLK  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- iVGA_HS  in  1  horizontal sync, active low
- iVGA_VS  in  1  vertical sync, active low
- iVGA_BLANK  in  1  high = active video
- iRed, iGreen, iBlue  in  1 each  pixel colour
- oCurrent_X  out  10  active-pixel column of output pixel
- oCurrent_Y  out  10  active-line row of output pixel
- oPix_Valid  out  1  output pixel valid
- oR, oG, oB  out  1 each  recovered colour
- oLocked  out  1  timing matches parameters
- oFrame_Start  out  1  one-cycle pulse per VS falling edge
- oTiming_Err  out  1  one-cycle pulse on loss of lock

Function
REQ-003 All inputs SHALL be registered once (stage 1); HS/VS falling edges SHALL be detected from stage-1 and stage-1-delayed values.
REQ-004 Pixel outputs (X, Y, valid, colour) SHALL be registered (stage 2): latency exactly 2 clocks from input pins.
REQ-005 h_cnt SHALL count clocks since the last HS falling edge, reset to 0 on that edge, saturate at 1023.
REQ-006 On each HS falling edge, h_cnt+1 SHALL be the measured line length; line is good iff it equals H_TOTAL and its active-pixel count is 0 or H_ACT.
REQ-007 X SHALL equal the number of BLANK-high samples already seen in the current line (first active pixel X=0), cleared on HS falling edge, saturating at 1023.
REQ-008 Y SHALL increment on an HS falling edge ending a line that contained active pixels, clear on VS falling edge, saturate at 1023.
REQ-009 Line counter SHALL count HS falling edges between VS falling edges; frame is good iff lines == V_TOTAL, active lines == V_ACT, and every line good.
REQ-010 Lock FSM states SHALL be SEARCH, VERIFY, LOCKED:
- SEARCH -> VERIFY on VS falling edge only if one HS falling edge has been seen since reset; good_cnt=0; no checks in SEARCH
- VERIFY: at each VS falling edge good frame increments good_cnt, bad frame clears it; good_cnt==LOCK_FRAMES -> LOCKED
- LOCKED: bad frame at VS falling edge -> SEARCH with oTiming_Err pulse
REQ-011 h_cnt reaching 1023 (HS missing) in VERIFY or LOCKED SHALL force SEARCH; oTiming_Err pulses only if leaving LOCKED.
REQ-012 oLocked SHALL be high exactly while state is LOCKED, registered.
REQ-013 oPix_Valid SHALL equal stage-1 BLANK AND LOCKED; oR/oG/oB SHALL be zero when oPix_Valid low.
REQ-014 oFrame_Start SHALL pulse for one clock on every VS falling edge, in all states.
REQ-015 HS and VS falling edges in the same cycle SHALL apply the line update first, then the frame evaluation including that line.

Reset
REQ-016 reset_n low SHALL immediately clear all outputs, counters, flags and good_cnt to 0 and state to SEARCH, regardless of clock.
REQ-017 After release, edge detection SHALL not fire on the first sampled cycle (delayed sync registers reset to 1).

Verification
REQ-018 Compliant 640x480 timing from reset -> oLocked rises at the 3rd VS falling edge (+1 clock).
REQ-019 Locked, first active pixel -> oPix_Valid=1, X=0, Y=0 two clocks after BLANK rises; last pixel X=639, Y=479.
REQ-020 Locked, one line of 799 clocks -> at next VS falling edge oLocked=0, oTiming_Err one-cycle pulse, state SEARCH.
REQ-021 Locked, HS held high -> after h_cnt saturates at 1023 oLocked=0, one oTiming_Err pulse.
REQ-022 VERIFY, frame with 524 lines -> good_cnt cleared, no lock; following two good frames -> lock.
REQ-023 reset_n low mid-frame -> all outputs 0 same cycle; after release relock per REQ-018.
